// File: rtl/fp_pkg.sv
// Shared float32 definitions for the packer/unpacker pair.
// Holds the IEEE-754 single-precision constants and field widths, the
// special-value class carried down the packer pipeline, and the unpacked
// float record exchanged with the unpacker side.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int SIGN_FW = 1;
    localparam int EXP_FW  = 8;
    localparam int FRAC_FW = 23;

    // Special-value class, resolved once at the input with nan > inf > zero.
    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [31:0] mant;
        logic        nan;
        logic        inf;
        logic        zero;
    } fp_unpacked_t;

    function automatic fp_class_t classify(input logic nan, input logic inf,
                                           input logic zero, input logic mant_zero);
        if (nan)
            return CLS_NAN;
        else if (inf)
            return CLS_INF;
        else if (zero || mant_zero)
            return CLS_ZERO;
        else
            return CLS_NUM;
    endfunction

endpackage

// File: rtl/fp_packer_lzc32.sv
// lzc32: combinational leading-zero counter.
// Ports:
//   a   in  32  word to scan
//   cnt out  6  number of zeros above the leading one (32 when a == 0)
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Scanning upwards lets the highest set bit win.
    always_comb begin
        cnt = 6'd32;
        for (int unsigned i = 0; i < 32; i++) begin
            if (a[i])
                cnt = 6'(31 - i);
        end
    end

endmodule

// File: rtl/fp_packer.sv
// fp_packer: normalise, round-to-nearest-even and pack into float32.
// Three-stage pipeline (normalise / denormalise+round / pack) with a global
// stall: every stage advances only when the output register can move.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_sign, in_exp       sign and signed exponent biased by 127
//   in_mant               unnormalised mantissa, binary point between bits 30 and 29
//   in_nan/inf/zero       special-case flags
//   out_valid/out_ready   output handshake
//   out_data              packed float32
//   out_ovf, out_unf      overflow to infinity, tiny and inexact
//   out_inexact           rounding discarded nonzero bits
module fp_packer
    import fp_pkg::*;
#(
    parameter int MANT_W = 32,   // the datapath assumes 32 (lzc32, bit-31 headroom)
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inexact
);

    localparam logic signed [EXP_W:0] E_OFF  = (EXP_W+1)'(30);
    localparam logic signed [EXP_W:0] E_ZERO = '0;
    localparam logic signed [EXP_W:0] E_ONE  = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] SH_LIM = (EXP_W+1)'(32);
    localparam logic signed [EXP_W:0] E_TOP  = (EXP_W+1)'(EXP_MAX);
    localparam logic [31:0]           ONES   = '1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: normalise ----------------
    logic [5:0]              lz;
    logic signed [EXP_W:0]   e_in, p_s, s1_e_nx;
    logic [31:0]             m_n;
    fp_class_t               cls_nx;

    lzc32 u_lzc (
        .a   (in_mant),
        .cnt (lz)
    );

    always_comb begin
        e_in    = {in_exp[EXP_W-1], in_exp};
        p_s     = (EXP_W+1)'(6'd31 - lz);
        s1_e_nx = e_in + p_s - E_OFF;
        m_n     = in_mant << lz;
        cls_nx  = classify(in_nan, in_inf, in_zero, in_mant == '0);
    end

    logic                  s1_valid, s1_sign;
    fp_class_t             s1_cls;
    logic signed [EXP_W:0] s1_e;
    logic [31:0]           s1_m;

    // ---------------- stage 2: denormalise and round ----------------
    logic                  tiny, big, dn_sticky, guard, sticky, rnd;
    logic signed [EXP_W:0] sh, e_rnd;
    logic [4:0]            sh5;
    logic [31:0]           m_d;
    logic [24:0]           sig_r;

    always_comb begin
        tiny      = s1_e <= E_ZERO;
        sh        = E_ONE - s1_e;
        big       = sh >= SH_LIM;
        sh5       = sh[4:0];
        m_d       = s1_m;
        dn_sticky = 1'b0;
        if (tiny) begin
            if (big) begin
                m_d       = '0;
                dn_sticky = |s1_m;
            end else begin
                m_d       = s1_m >> sh5;
                dn_sticky = |(s1_m & ~(ONES << sh5));
            end
        end
        guard  = m_d[7];
        sticky = (|m_d[6:0]) | dn_sticky;
        rnd    = guard & (sticky | m_d[8]);
        sig_r  = {1'b0, m_d[31:8]} + 25'(rnd);
        // A subnormal carrying into bit 23 is exactly 2^-126, i.e. field 1;
        // a normal carrying out of bit 23 bumps the exponent and leaves frac 0.
        if (tiny) begin
            e_rnd    = '0;
            e_rnd[0] = sig_r[23];
        end else begin
            e_rnd = s1_e + (EXP_W+1)'(sig_r[24]);
        end
    end

    logic                  s2_valid, s2_sign, s2_tiny, s2_inexact;
    fp_class_t             s2_cls;
    logic signed [EXP_W:0] s2_e;
    logic [22:0]           s2_frac;

    // ---------------- stage 3: pack ----------------
    logic [31:0] pk_data;
    logic        pk_ovf, pk_unf, pk_inx;

    always_comb begin
        pk_data = '0;
        pk_ovf  = 1'b0;
        pk_unf  = 1'b0;
        pk_inx  = 1'b0;
        case (s2_cls)
            CLS_NAN:  pk_data = QNAN;
            CLS_INF:  pk_data = {s2_sign, 8'hFF, 23'h0};
            CLS_ZERO: pk_data = {s2_sign, 31'h0};
            default: begin
                if (s2_e >= E_TOP) begin
                    pk_data = {s2_sign, 8'hFF, 23'h0};
                    pk_ovf  = 1'b1;
                    pk_inx  = 1'b1;
                end else begin
                    pk_data = {s2_sign, s2_e[EXP_FW-1:0], s2_frac};
                    pk_unf  = s2_tiny & s2_inexact;
                    pk_inx  = s2_inexact;
                end
            end
        endcase
    end

    // Valids and visible outputs are reset; internal payload is not.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data    <= pk_data;
                out_ovf     <= pk_ovf;
                out_unf     <= pk_unf;
                out_inexact <= pk_inx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_cls  <= cls_nx;
                s1_e    <= s1_e_nx;
                s1_m    <= m_n;
            end
            if (s1_valid) begin
                s2_sign    <= s1_sign;
                s2_cls     <= s1_cls;
                s2_e       <= e_rnd;
                s2_frac    <= sig_r[22:0];
                s2_tiny    <= tiny;
                s2_inexact <= guard | sticky;
            end
        end
    end

endmodule

// File: tb/tb_fp_packer.sv
module tb_fp_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_nan, in_inf, in_zero;
    logic [9:0]  in_exp;
    logic [31:0] in_mant;
    logic        out_valid, out_ready, out_ovf, out_unf, out_inexact;
    logic [31:0] out_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fp_packer #(.MANT_W(32), .EXP_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mant     (in_mant),
        .in_nan      (in_nan),
        .in_inf      (in_inf),
        .in_zero     (in_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    typedef struct {
        string       name;
        logic        sign;
        logic [9:0]  exp;
        logic [31:0] mant;
        logic        nan, inf, zero;
        logic [31:0] data;
        logic [2:0]  flags;   // {ovf, unf, inexact}
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_num(input logic s, input logic [9:0] e, input logic [31:0] m);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_zero  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int sent, got, extra;
        logic stall_seen;
        logic [31:0] held;
        logic [31:0] bp_exp[5];

        vecs[0]  = '{"norm_32",       0, 10'd132,  32'h4000_0000, 0, 0, 0, 32'h4200_0000, 3'b000};
        vecs[1]  = '{"unnorm_4",      0, 10'd132,  32'h0800_0000, 0, 0, 0, 32'h4080_0000, 3'b000};
        vecs[2]  = '{"headroom_1",    0, 10'd126,  32'h8000_0000, 0, 0, 0, 32'h3F80_0000, 3'b000};
        vecs[3]  = '{"tie_even",      0, 10'd127,  32'h4000_0040, 0, 0, 0, 32'h3F80_0000, 3'b001};
        vecs[4]  = '{"tie_odd",       0, 10'd127,  32'h4000_00C0, 0, 0, 0, 32'h3F80_0002, 3'b001};
        vecs[5]  = '{"above_half",    0, 10'd127,  32'h4000_0041, 0, 0, 0, 32'h3F80_0001, 3'b001};
        vecs[6]  = '{"round_ovf",     0, 10'd254,  32'h7FFF_FFFF, 0, 0, 0, 32'h7F80_0000, 3'b101};
        vecs[7]  = '{"subnorm_exact", 0, 10'd1,    32'h1055_6400, 0, 0, 0, 32'h0020_AAC8, 3'b000};
        vecs[8]  = '{"underflow_0",   0, 10'h3D8,  32'h4000_0000, 0, 0, 0, 32'h0000_0000, 3'b011};
        vecs[9]  = '{"sub_to_min",    0, 10'h3FF,  32'hFFFF_FFFF, 0, 0, 0, 32'h0080_0000, 3'b011};
        vecs[10] = '{"big_exp_ovf",   1, 10'd300,  32'h4000_0000, 0, 0, 0, 32'hFF80_0000, 3'b101};
        vecs[11] = '{"nan_over_inf",  1, 10'd5,    32'h1234_5678, 1, 1, 0, 32'h7FC0_0000, 3'b000};
        vecs[12] = '{"neg_inf",       1, 10'd5,    32'h1234_5678, 0, 1, 1, 32'hFF80_0000, 3'b000};
        vecs[13] = '{"neg_zero_flag", 1, 10'd130,  32'h4000_0000, 0, 0, 1, 32'h8000_0000, 3'b000};
        vecs[14] = '{"zero_mant",     1, 10'd130,  32'h0000_0000, 0, 0, 0, 32'h8000_0000, 3'b000};

        reset     = 1'b1;
        out_ready = 1'b1;
        drive_num(0, '0, '0);
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,       32'h0);
        check("rst_flags",     32'({out_ovf, out_unf, out_inexact}), 32'd0);

        // ---- table-driven single transactions ----
        foreach (vecs[i]) begin
            @(negedge clk);
            drive_num(vecs[i].sign, vecs[i].exp, vecs[i].mant);
            in_nan  = vecs[i].nan;
            in_inf  = vecs[i].inf;
            in_zero = vecs[i].zero;
            #4;
            check({vecs[i].name, "_accept"}, 32'(in_ready), 32'd1);
            k = 0;
            for (int c = 1; c <= 10 && k == 0; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #4;
                if (out_valid) k = c;
            end
            check({vecs[i].name, "_latency"}, 32'(k), 32'd3);
            if (k != 0) begin
                check({vecs[i].name, "_data"},  out_data, vecs[i].data);
                check({vecs[i].name, "_flags"}, 32'({out_ovf, out_unf, out_inexact}),
                      32'(vecs[i].flags));
            end
        end

        // ---- backpressure: 5 words, out_ready low for the first 6 cycles ----
        for (int i = 0; i < 5; i++) bp_exp[i] = {1'b0, 8'(128 + i), 23'h0};
        sent = 0;
        got = 0;
        stall_seen = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            drive_num(0, 10'(128 + sent), 32'h4000_0000);
            in_valid = (sent < 5);
            #4;
            if (out_valid && !out_ready) begin
                if (!stall_seen) begin
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    stall_seen = 1'b1;
                    held = out_data;
                end else begin
                    check("bp_hold_data", out_data, held);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("bp_order", out_data, bp_exp[got]);
                got++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_stall_seen", 32'(stall_seen), 32'd1);
        check("bp_count", 32'(got), 32'd5);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #4;
            if (out_valid) extra++;
        end
        check("bp_no_dup", 32'(extra), 32'd0);

        // ---- reset with two words in flight ----
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_num(0, 10'(140 + c), 32'h4000_0000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #4;
            if (out_valid) extra++;
        end
        check("mid_rst_no_stale", 32'(extra), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
